std_wrr_arbiter: RTL

Weighted round-robin arbiter that shares one downstream resource between N requesters. Each grant is held for a programmable number of accepted beats, the requester's quota. A round-robin pointer guarantees fairness between grants. The block sits in the std library next to the value counter and uses a down-counter internally to track each requester's quota; requesters present `i_req` and the shared resource returns `i_ack` per accepted beat.

---
 rtl/std_wrr_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/std_wrr_arbiter.sv
// Weighted round-robin arbiter: one-hot registered grant held for a
// per-requester quota of acked beats, fair rotation between grants.
module std_wrr_arbiter #(
    parameter int N  = 4,
    parameter int QW = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic [N-1:0]    i_req,
    input  logic [N*QW-1:0] i_weight,
    input  logic            i_ack,
    output logic [N-1:0]    o_grant,
    output logic            o_grant_valid,
    output logic [IW-1:0]   o_grant_index,
    output logic [QW-1:0]   o_remaining,
    output logic            o_last
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [QW-1:0] rem_q, rem_d;

    logic [IW-1:0]  idx_succ;
    logic [IW-1:0]  scan_base;
    logic [2*N-1:0] req_rot;
    logic           win_found;
    logic [IW-1:0]  win_idx;
    logic [IW:0]    win_sum;
    logic [QW-1:0]  win_weight;
    logic [QW-1:0]  win_load;
    logic [N-1:0]   win_onehot;
    logic           cur_req;
    logic           rem_one;
    logic           release_now;

    assign idx_succ = (int'(idx_q) == N - 1) ? '0 : idx_q + 1'b1;

    // In GRANT the scan starts after the holder, so it wins only when alone.
    assign scan_base = (state_q == GRANT) ? idx_succ : ptr_q;
    assign req_rot   = {i_req, i_req} >> scan_base;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_sum   = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, scan_base} + (IW+1)'(i);
                if (win_sum >= (IW+1)'(N)) begin
                    win_sum = win_sum - (IW+1)'(N);
                end
                win_idx = win_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        win_weight = '0;
        win_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (win_idx == IW'(k)) begin
                win_weight    = i_weight[k*QW +: QW];
                win_onehot[k] = 1'b1;
            end
        end
    end

    // A zero quota still buys one beat.
    assign win_load = (win_weight == '0) ? QW'(1) : win_weight;

    assign cur_req     = |(i_req & grant_q);
    assign rem_one     = (rem_q == QW'(1));
    assign release_now = (i_ack && rem_one) || !cur_req;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        if (i_clear) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = '0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_d = GRANT;
                        grant_d = win_onehot;
                        idx_d   = win_idx;
                        rem_d   = win_load;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_d = idx_succ;
                        if (win_found) begin
                            grant_d = win_onehot;
                            idx_d   = win_idx;
                            rem_d   = win_load;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                            rem_d   = '0;
                        end
                    end else if (i_ack) begin
                        rem_d = rem_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_grant_valid = (state_q == GRANT);
    assign o_grant_index = idx_q;
    assign o_remaining   = rem_q;
    assign o_last        = o_grant_valid && rem_one;

endmodule
